// File: rtl/ysyx_22040386_csr_pkg.sv
// Shared CSR constants: addresses, decode state encodings, mstatus fields and reset value.
// The decode stage imports the same package. YSYX_22040386_CSR_MCYCLE_EN (in the top) enables mcycle.
package ysyx_22040386_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hb00;

    typedef enum logic [1:0] {
        CSR_STATE_IDLE  = 2'b00,
        CSR_STATE_RW    = 2'b01,
        CSR_STATE_ECALL = 2'b10,
        CSR_STATE_MRET  = 2'b11
    } csr_state_e;

    typedef enum logic {
        TRAP_IDLE   = 1'b0,
        TRAP_ACTIVE = 1'b1
    } trap_state_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Non-zero reset value keeps difftest aligned with the reference model.
    localparam logic [63:0] MSTATUS_RESET = 64'h0000_000a_0000_1800;

endpackage

// File: rtl/ysyx_22040386_csr_trapfsm.sv
// IDLE/TRAP sequencer: latches the ecall/mret target and raises a one-cycle redirect.
// While in TRAP the committing instruction is ignored, so o_commit gates all CSR updates.
module ysyx_22040386_csr_trapfsm
    import ysyx_22040386_csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [1:0]      i_state,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    output logic            o_commit,
    output logic            o_redirect,
    output logic [63:0]     o_redirect_pc,
    output logic            o_busy
);

    trap_state_e state_q, state_d;
    logic [63:0] redirect_pc_q, redirect_pc_d;
    logic        is_ecall, is_mret;

    assign is_ecall = (i_state == CSR_STATE_ECALL);
    assign is_mret  = (i_state == CSR_STATE_MRET);

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        o_commit      = 1'b0;
        case (state_q)
            TRAP_IDLE: begin
                o_commit = i_valid;
                if (i_valid && (is_ecall || is_mret)) begin
                    state_d       = TRAP_ACTIVE;
                    redirect_pc_d = is_ecall ? (64'(i_mtvec) & ~64'h3) : 64'(i_mepc);
                end
            end
            default: state_d = TRAP_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= TRAP_IDLE;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign o_redirect    = (state_q == TRAP_ACTIVE);
    assign o_busy        = (state_q == TRAP_ACTIVE);
    assign o_redirect_pc = redirect_pc_q;

endmodule

// File: rtl/ysyx_22040386_csr_unit.sv
// M-mode CSR file with combinational read mux; traps sequenced by ysyx_22040386_csr_trapfsm.
// Define YSYX_22040386_CSR_MCYCLE_EN to build the mcycle counter; otherwise mcycle reads 0.
module ysyx_22040386_csr_unit
    import ysyx_22040386_csr_pkg::*;
#(
    parameter int               XLEN        = 64,
    parameter logic [XLEN-1:0]  TRAP_MCAUSE = 64'd11
) (
    input  logic            i_CSR_clk,
    input  logic            i_CSR_rst,
    input  logic            i_CSR_valid,
    input  logic            i_CSR_ren,
    input  logic            i_CSR_wen,
    input  logic [1:0]      i_CSR_state,
    input  logic [11:0]     i_CSR_raddr,
    input  logic [11:0]     i_CSR_waddr,
    input  logic [XLEN-1:0] i_CSR_wdata,
    input  logic [63:0]     i_CSR_pc,
    output logic [XLEN-1:0] o_CSR_rdata,
    output logic            o_CSR_redirect,
    output logic [63:0]     o_CSR_redirect_pc,
    output logic            o_CSR_busy
);

    logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [XLEN-1:0] mip_q, mip_d;
`ifdef YSYX_22040386_CSR_MCYCLE_EN
    logic [XLEN-1:0] mcycle_q, mcycle_d;
`endif
    logic            commit, wr_en;
    logic [XLEN-1:0] wr_old, wr_val;

    function automatic logic [XLEN-1:0] csr_read(input logic [11:0] addr);
        logic [XLEN-1:0] r;
        r = '0;
        case (addr)
            CSR_MSTATUS:  r = mstatus_q;
            CSR_MIE:      r = mie_q;
            CSR_MTVEC:    r = mtvec_q;
            CSR_MSCRATCH: r = mscratch_q;
            CSR_MEPC:     r = mepc_q;
            CSR_MCAUSE:   r = mcause_q;
            CSR_MIP:      r = mip_q;
`ifdef YSYX_22040386_CSR_MCYCLE_EN
            CSR_MCYCLE:   r = mcycle_q;
`endif
            default:      r = '0;
        endcase
        return r;
    endfunction

    assign o_CSR_rdata = csr_read(i_CSR_raddr);
    assign wr_old      = csr_read(i_CSR_waddr);

    // csrrs with rs1 == 0 must not write, so side effects on read-only bits never fire.
    assign wr_en  = commit && (i_CSR_state == CSR_STATE_RW) &&
                    (i_CSR_wen || (i_CSR_ren && (i_CSR_wdata != '0)));
    assign wr_val = i_CSR_wen ? i_CSR_wdata : (wr_old | i_CSR_wdata);

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mip_d      = mip_q;
        if (wr_en) begin
            case (i_CSR_waddr)
                CSR_MSTATUS:  mstatus_d  = wr_val;
                CSR_MIE:      mie_d      = wr_val;
                CSR_MTVEC:    mtvec_d    = wr_val;
                CSR_MSCRATCH: mscratch_d = wr_val;
                CSR_MEPC:     mepc_d     = wr_val;
                CSR_MCAUSE:   mcause_d   = wr_val;
                CSR_MIP:      mip_d      = wr_val;
                default:      ;
            endcase
        end
        // Trap side effects come last so they override any same-cycle RW write.
        if (commit && (i_CSR_state == CSR_STATE_ECALL)) begin
            mepc_d                                 = XLEN'(i_CSR_pc);
            mcause_d                               = TRAP_MCAUSE;
            mstatus_d[MSTATUS_MPIE]                = mstatus_q[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]                 = 1'b0;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end
        if (commit && (i_CSR_state == CSR_STATE_MRET)) begin
            mstatus_d[MSTATUS_MIE]                 = mstatus_q[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE]                = 1'b1;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end
    end

    always_ff @(posedge i_CSR_clk) begin
        if (i_CSR_rst) begin
            mstatus_q  <= XLEN'(MSTATUS_RESET);
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mip_q      <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mip_q      <= mip_d;
        end
    end

`ifdef YSYX_22040386_CSR_MCYCLE_EN
    always_comb begin
        mcycle_d = mcycle_q + 1'b1;
        if (wr_en && (i_CSR_waddr == CSR_MCYCLE)) mcycle_d = wr_val;
    end

    always_ff @(posedge i_CSR_clk) begin
        if (i_CSR_rst) mcycle_q <= '0;
        else           mcycle_q <= mcycle_d;
    end
`endif

    ysyx_22040386_csr_trapfsm #(.XLEN(XLEN)) u_trapfsm (
        .i_clk         (i_CSR_clk),
        .i_rst         (i_CSR_rst),
        .i_valid       (i_CSR_valid),
        .i_state       (i_CSR_state),
        .i_mtvec       (mtvec_q),
        .i_mepc        (mepc_q),
        .o_commit      (commit),
        .o_redirect    (o_CSR_redirect),
        .o_redirect_pc (o_CSR_redirect_pc),
        .o_busy        (o_CSR_busy)
    );

endmodule
